// File: rtl/serial_subtractor.sv
// Bit-serial a-b (LSB first, one full-subtractor cell); done pulses WIDTH cycles after the accepting edge.
// `define SERIAL_SUB_ADD_EN adds a mode port (1=subtract, 0=add). start is ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic               d_bit, br_nxt;
`ifdef SERIAL_SUB_ADD_EN
    logic               mode_q, mode_d;
`endif

    // br_q doubles as the carry when adding; the sum bit equation is shared.
    always_comb begin
        d_bit  = sa_q[0] ^ sb_q[0] ^ br_q;
        br_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
`ifdef SERIAL_SUB_ADD_EN
        if (!mode_q) begin
            br_nxt = (sa_q[0] & sb_q[0]) | (br_q & (sa_q[0] ^ sb_q[0]));
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        work_d  = work_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_ADD_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_EN
                    mode_d  = mode;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                work_d = {d_bit, work_q[WIDTH-1:1]};
                br_d   = br_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {d_bit, work_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            work_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
            mode_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            work_q  <= work_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_ADD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=8 with hand-computed results.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    int n_checks = 0;
    int n_fail   = 0;
    int done_pulses = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_SUB_ADD_EN
        .mode  (mode),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns one time unit after the accepting edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic mv);
        @(negedge clk);
        a = av;
        b = bv;
        mode = mv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; checks cycles waited and busy cycles seen on the way.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        int nbusy = 0;
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) begin
                got = 1;
            end else begin
                if (busy) nbusy++;
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat);
    endtask

    task automatic sub_vec(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] exp_d, input logic exp_b);
        start_op(av, bv, 1'b1);
        wait_done(tag, 8);
        check({tag, "_diff"}, diff, exp_d);
        check({tag, "_bout"}, bout, exp_b);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int d0;
        clk = 0;
        rst = 0;
        start = 0;
        a = 0;
        b = 0;
        mode = 1;
        #2 rst = 1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        @(negedge clk);
        rst = 0;

        sub_vec("100m25", 8'd100, 8'd25, 8'd75, 1'b0);
        sub_vec("25m100", 8'd25, 8'd100, 8'hB5, 1'b1);
        sub_vec("0m1", 8'h00, 8'h01, 8'hFF, 1'b1);
        sub_vec("0m0", 8'h00, 8'h00, 8'h00, 1'b0);

        // start during RUN must be ignored
        start_op(8'd50, 8'd20, 1'b1);
        d0 = done_pulses;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("mid", 5);
        check("mid_diff", diff, 8'd30);
        check("mid_bout", bout, 0);
        repeat (4) begin @(posedge clk); #1; end
        check("mid_one_done", done_pulses - d0, 1);
        check("mid_idle", busy, 0);
        check("mid_diff_hold", diff, 8'd30);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd3; b = 8'd9;
        wait_done("b2b1", 8);
        check("b2b1_diff", diff, 8'd6);
        check("b2b1_bout", bout, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_no_gap_busy", busy, 1);
        check("b2b_done_single", done, 0);
        wait_done("b2b2", 8);
        check("b2b2_diff", diff, 8'hFA);
        check("b2b2_bout", bout, 1);

        // reset mid-run at bit 4
        start_op(8'd200, 8'd1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_diff", diff, 0);
        check("arst_bout", bout, 0);
        d0 = done_pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("arst_no_done", done_pulses - d0, 0);
        check("arst_idle", busy, 0);
        sub_vec("7m7", 8'd7, 8'd7, 8'd0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
        start_op(8'd200, 8'd100, 1'b0);
        wait_done("add", 8);
        check("add_diff", diff, 8'd44);
        check("add_cout", bout, 1);
        start_op(8'd200, 8'd100, 1'b1);
        wait_done("sub_mode", 8);
        check("sub_mode_diff", diff, 8'd100);
        check("sub_mode_bout", bout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
